// File: rtl/music_pkg.sv
// Shared constants, state encoding and debug view for the song reader.
package music_pkg;

    localparam int SONG_W = 2;                 // 4 songs
    localparam int IDX_W  = 5;                 // 32 entries per song
    localparam int NOTE_W = 6;                 // note code, 0 = rest
    localparam int DUR_W  = 6;                 // duration in beats, 0 = end of song
    localparam int ADDR_W = SONG_W + IDX_W;
    localparam int DATA_W = NOTE_W + DUR_W;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;
    localparam logic [DUR_W-1:0]  END_MARK  = '0;
    localparam logic [IDX_W-1:0]  LAST_IDX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_LOAD    = 3'd3,
        ST_PLAY    = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_END     = 3'd6
    } state_t;

    // Internal view exported for checkers: FSM state and position in the song.
    typedef struct packed {
        state_t            state;
        logic [IDX_W-1:0]  note_index;
    } dbg_t;

    // ROM address layout: song select in the upper bits, note index below.
    function automatic logic [ADDR_W-1:0] make_addr(input logic [SONG_W-1:0] song,
                                                    input logic [IDX_W-1:0]  idx);
        return {song, idx};
    endfunction

endpackage

// File: rtl/song_reader_if.sv
// Bundle of the control, song-ROM and note-player/counter signals of the song reader.
//
// Signalling: there is no valid/ready pair here. play is a level; next_song and
// timer_done are single-cycle strobes sampled on the rising clock edge.
// rom_data answers rom_addr exactly one cycle later (synchronous ROM).
// new_note, timer_clear and song_done are single-cycle pulses from the reader.
interface song_reader_if;
    import music_pkg::*;

    logic                 play;
    logic                 next_song;
    logic                 timer_done;
    logic [ADDR_W-1:0]    rom_addr;
    logic [DATA_W-1:0]    rom_data;
    logic [NOTE_W-1:0]    note_to_play;
    logic [DUR_W-1:0]     duration_to_load;
    logic                 new_note;
    logic                 timer_clear;
    logic                 song_done;
    logic [SONG_W-1:0]    current_song;
    dbg_t                 dbg;

    modport master (
        input  play, next_song, timer_done, rom_data,
        output rom_addr, note_to_play, duration_to_load,
               new_note, timer_clear, song_done, current_song, dbg
    );

    modport slave (
        output play, next_song, timer_done, rom_data,
        input  rom_addr, note_to_play, duration_to_load,
               new_note, timer_clear, song_done, current_song, dbg
    );

endinterface

// File: rtl/song_reader.sv
// Note sequencer: walks the selected song in the ROM, hands each note to the
// player / duration counter and waits for the counter's done strobe.
module song_reader
    import music_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    song_reader_if.master bus
);

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     note_index;
    logic [SONG_W-1:0]    song_q;
    logic [ADDR_W-1:0]    rom_addr_q;
    logic [NOTE_W-1:0]    note_q;
    logic [DUR_W-1:0]     dur_q;
    logic                 new_note_q;
    logic                 clear_q;

    logic [NOTE_W-1:0]    rom_note;
    logic [DUR_W-1:0]     rom_dur;
    logic                 accept_done;

    assign rom_note = bus.rom_data[DATA_W-1:DUR_W];
    assign rom_dur  = bus.rom_data[DUR_W-1:0];

    // A done strobe counts only while running and not in the clearing cycle,
    // where it could be a leftover from the previous note.
    assign accept_done = bus.play && bus.timer_done && !clear_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; next_song overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (bus.next_song) begin
            state_nxt = bus.play ? ST_FETCH : ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:    if (bus.play) state_nxt = ST_FETCH;
                ST_FETCH:   state_nxt = ST_WAIT;
                ST_WAIT:    state_nxt = ST_LOAD;
                ST_LOAD:    state_nxt = (rom_dur == END_MARK) ? ST_END : ST_PLAY;
                ST_PLAY:    if (accept_done) state_nxt = ST_ADVANCE;
                ST_ADVANCE: state_nxt = (note_index == LAST_IDX) ? ST_END : ST_FETCH;
                ST_END:     state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Song/index counters, ROM address and the note registers with their pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            note_index <= '0;
            song_q     <= '0;
            rom_addr_q <= '0;
            note_q     <= REST_NOTE;
            dur_q      <= '0;
            new_note_q <= 1'b0;
            clear_q    <= 1'b0;
        end else begin
            new_note_q <= 1'b0;
            clear_q    <= 1'b0;
            if (bus.next_song) begin
                song_q     <= song_q + 1'b1;
                note_index <= '0;
                note_q     <= REST_NOTE;
                clear_q    <= 1'b1;
            end else begin
                unique case (state)
                    ST_FETCH: rom_addr_q <= make_addr(song_q, note_index);
                    ST_LOAD: begin
                        if (rom_dur != END_MARK) begin
                            note_q     <= rom_note;
                            dur_q      <= rom_dur;
                            new_note_q <= 1'b1;
                            clear_q    <= 1'b1;
                        end
                    end
                    ST_ADVANCE: begin
                        // The last index ends the song instead of running into the next one.
                        if (note_index != LAST_IDX) note_index <= note_index + 1'b1;
                    end
                    ST_END: begin
                        note_index <= '0;
                        note_q     <= REST_NOTE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output drive: registered values plus the END-state song_done pulse.
    always_comb begin
        bus.rom_addr         = rom_addr_q;
        bus.note_to_play     = note_q;
        bus.duration_to_load = dur_q;
        bus.new_note         = new_note_q;
        bus.timer_clear      = clear_q;
        bus.song_done        = (state == ST_END);
        bus.current_song     = song_q;
        bus.dbg.state        = state;
        bus.dbg.note_index   = note_index;
    end

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader with a behavioural synchronous song ROM.
module tb_song_reader;
    import music_pkg::*;

    logic clk = 1'b0;
    logic reset;
    song_reader_if bus();

    song_reader dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural synchronous ROM: data one cycle after the address.
    logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    logic [DATA_W-1:0] exp_q[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;
    bit wrap_seen = 1'b0;

    // Any address of song 2 index 0 while checking song 1 means a wrap.
    always @(negedge clk) if (bus.rom_addr == ADDR_W'(64)) wrap_seen = 1'b1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not end, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_note(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.new_note && n < 60);
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.play = 1'b0; bus.next_song = 1'b0; bus.timer_done = 1'b0;
        tick(); tick();
        chk_cnt++; if (bus.dbg.state !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", bus.dbg.state, ST_IDLE); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== '0) $display("FAIL rst_addr: got %0d want 0", bus.rom_addr); else pass_cnt++;
        chk_cnt++; if ({bus.note_to_play, bus.duration_to_load} !== '0) $display("FAIL rst_note: got %h want 0", {bus.note_to_play, bus.duration_to_load}); else pass_cnt++;
        chk_cnt++; if ({bus.new_note, bus.timer_clear, bus.song_done} !== 3'b000) $display("FAIL rst_pulses: got %b want 000", {bus.new_note, bus.timer_clear, bus.song_done}); else pass_cnt++;
        chk_cnt++; if (bus.current_song !== '0) $display("FAIL rst_song: got %0d want 0", bus.current_song); else pass_cnt++;
        reset = 1'b0;
        tick();
        chk_cnt++; if (bus.dbg.state !== ST_IDLE) $display("FAIL idle_hold: got %0d want %0d", bus.dbg.state, ST_IDLE); else pass_cnt++;
    endtask

    task automatic test_first_note();
        int n;
        logic [DATA_W-1:0] exp;
        exp_q.push_back(rom[0]);
        bus.play = 1'b1;
        wait_note(n);
        chk_cnt++; if (n !== 4) $display("FAIL first_lat: got %0d cycles want 4", n); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(0)) $display("FAIL first_addr: got %0d want 0", bus.rom_addr); else pass_cnt++;
        chk_cnt++; if (bus.timer_clear !== 1'b1) $display("FAIL first_clear: got %b want 1", bus.timer_clear); else pass_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk_cnt++; if ({bus.note_to_play, bus.duration_to_load} !== exp) $display("FAIL first_data: got %h want %h", {bus.note_to_play, bus.duration_to_load}, exp); else pass_cnt++;
        // A done strobe in the clearing cycle must be ignored.
        bus.timer_done = 1'b1;
        tick();
        bus.timer_done = 1'b0;
        chk_cnt++; if (bus.dbg.state !== ST_PLAY) $display("FAIL done_ignored: state got %0d want %0d", bus.dbg.state, ST_PLAY); else pass_cnt++;
        chk_cnt++; if ({bus.new_note, bus.timer_clear} !== 2'b00) $display("FAIL pulse_width: got %b want 00", {bus.new_note, bus.timer_clear}); else pass_cnt++;
    endtask

    task automatic test_advance_and_end();
        int n;
        int cnt;
        logic [DATA_W-1:0] exp;
        exp_q.push_back(rom[1]);
        bus.timer_done = 1'b1;
        tick();
        bus.timer_done = 1'b0;
        bus.play = 1'b0;   // fetch in flight still completes and parks in PLAY
        wait_note(n);
        chk_cnt++; if (n + 1 !== 5) $display("FAIL adv_lat: got %0d cycles want 5", n + 1); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(1)) $display("FAIL adv_addr: got %0d want 1", bus.rom_addr); else pass_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk_cnt++; if ({bus.note_to_play, bus.duration_to_load} !== exp) $display("FAIL adv_data: got %h want %h", {bus.note_to_play, bus.duration_to_load}, exp); else pass_cnt++;
        // Paused: done strobes are not accepted, everything holds.
        tick();
        bus.timer_done = 1'b1;
        repeat (3) tick();
        bus.timer_done = 1'b0;
        chk_cnt++; if (bus.dbg.state !== ST_PLAY) $display("FAIL pause_state: got %0d want %0d", bus.dbg.state, ST_PLAY); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(1)) $display("FAIL pause_addr: got %0d want 1", bus.rom_addr); else pass_cnt++;
        chk_cnt++; if (bus.note_to_play !== rom[1][DATA_W-1:DUR_W]) $display("FAIL pause_note: got %0d want %0d", bus.note_to_play, rom[1][DATA_W-1:DUR_W]); else pass_cnt++;
        // Resume together with a done strobe; entry 2 is the end marker.
        bus.play = 1'b1;
        bus.timer_done = 1'b1;
        tick();
        bus.play = 1'b0;
        bus.timer_done = 1'b0;
        cnt = 0;
        while (!bus.song_done && cnt < 40) begin tick(); cnt++; end
        chk_cnt++; if (cnt !== 4) $display("FAIL end_lat: got %0d cycles want 4", cnt); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(2)) $display("FAIL end_addr: got %0d want 2", bus.rom_addr); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.song_done !== 1'b0) $display("FAIL end_pulse: got %b want 0", bus.song_done); else pass_cnt++;
        chk_cnt++; if (bus.dbg.state !== ST_IDLE) $display("FAIL end_idle: got %0d want %0d", bus.dbg.state, ST_IDLE); else pass_cnt++;
        chk_cnt++; if (bus.note_to_play !== REST_NOTE) $display("FAIL end_note: got %0d want 0", bus.note_to_play); else pass_cnt++;
        chk_cnt++; if (bus.dbg.note_index !== '0) $display("FAIL end_index: got %0d want 0", bus.dbg.note_index); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(2)) $display("FAIL end_addr_hold: got %0d want 2", bus.rom_addr); else pass_cnt++;
    endtask

    task automatic test_full_song();
        int n;
        int cnt;
        logic [DATA_W-1:0] exp;
        bus.next_song = 1'b1;
        tick();
        bus.next_song = 1'b0;
        chk_cnt++; if (bus.current_song !== SONG_W'(1)) $display("FAIL ns_song: got %0d want 1", bus.current_song); else pass_cnt++;
        chk_cnt++; if ({bus.timer_clear, bus.song_done} !== 2'b10) $display("FAIL ns_pulses: got %b want 10", {bus.timer_clear, bus.song_done}); else pass_cnt++;
        chk_cnt++; if (bus.dbg.state !== ST_IDLE) $display("FAIL ns_idle: got %0d want %0d", bus.dbg.state, ST_IDLE); else pass_cnt++;
        tick();
        wrap_seen = 1'b0;
        bus.play = 1'b1;
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back(rom[32 + i]);
            wait_note(n);
            chk_cnt++; if (n !== 4) $display("FAIL full_lat[%0d]: got %0d want 4", i, n); else pass_cnt++;
            chk_cnt++; if (bus.rom_addr !== ADDR_W'(32 + i)) $display("FAIL full_addr[%0d]: got %0d want %0d", i, bus.rom_addr, 32 + i); else pass_cnt++;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            chk_cnt++; if ({bus.note_to_play, bus.duration_to_load} !== exp) $display("FAIL full_data[%0d]: got %h want %h", i, {bus.note_to_play, bus.duration_to_load}, exp); else pass_cnt++;
            tick();
            bus.timer_done = 1'b1;
            tick();
            bus.timer_done = 1'b0;
        end
        bus.play = 1'b0;
        cnt = 0;
        while (!bus.song_done && cnt < 40) begin tick(); cnt++; end
        chk_cnt++; if (cnt !== 1) $display("FAIL full_end_lat: got %0d want 1", cnt); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(63)) $display("FAIL full_end_addr: got %0d want 63", bus.rom_addr); else pass_cnt++;
        repeat (8) tick();
        chk_cnt++; if (wrap_seen !== 1'b0) $display("FAIL full_wrap: got %b want 0", wrap_seen); else pass_cnt++;
        chk_cnt++; if (bus.dbg.state !== ST_IDLE) $display("FAIL full_idle: got %0d want %0d", bus.dbg.state, ST_IDLE); else pass_cnt++;
    endtask

    task automatic test_next_song_priority();
        int n;
        logic [DATA_W-1:0] exp;
        repeat (2) begin
            bus.next_song = 1'b1;
            tick();
            bus.next_song = 1'b0;
        end
        chk_cnt++; if (bus.current_song !== SONG_W'(3)) $display("FAIL pri_song3: got %0d want 3", bus.current_song); else pass_cnt++;
        exp_q.push_back(rom[96]);
        bus.play = 1'b1;
        wait_note(n);
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(96)) $display("FAIL pri_addr3: got %0d want 96", bus.rom_addr); else pass_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk_cnt++; if ({bus.note_to_play, bus.duration_to_load} !== exp) $display("FAIL pri_data3: got %h want %h", {bus.note_to_play, bus.duration_to_load}, exp); else pass_cnt++;
        tick();
        exp_q.push_back(rom[0]);
        bus.next_song = 1'b1;
        bus.timer_done = 1'b1;
        tick();
        bus.next_song = 1'b0;
        bus.timer_done = 1'b0;
        chk_cnt++; if (bus.current_song !== SONG_W'(0)) $display("FAIL pri_wrap: got %0d want 0", bus.current_song); else pass_cnt++;
        chk_cnt++; if ({bus.timer_clear, bus.new_note, bus.song_done} !== 3'b100) $display("FAIL pri_pulses: got %b want 100", {bus.timer_clear, bus.new_note, bus.song_done}); else pass_cnt++;
        chk_cnt++; if (bus.dbg.state !== ST_FETCH) $display("FAIL pri_state: got %0d want %0d", bus.dbg.state, ST_FETCH); else pass_cnt++;
        chk_cnt++; if (bus.dbg.note_index !== '0) $display("FAIL pri_index: got %0d want 0", bus.dbg.note_index); else pass_cnt++;
        chk_cnt++; if (bus.note_to_play !== REST_NOTE) $display("FAIL pri_note: got %0d want 0", bus.note_to_play); else pass_cnt++;
        tick();
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(0)) $display("FAIL pri_addr0: got %0d want 0", bus.rom_addr); else pass_cnt++;
        wait_note(n);
        chk_cnt++; if (n !== 2) $display("FAIL pri_lat: got %0d want 2", n); else pass_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk_cnt++; if ({bus.note_to_play, bus.duration_to_load} !== exp) $display("FAIL pri_data0: got %h want %h", {bus.note_to_play, bus.duration_to_load}, exp); else pass_cnt++;
    endtask

    task automatic test_reset_mid_note();
        int n;
        logic [DATA_W-1:0] exp;
        tick();
        exp_q.push_back(rom[32]);
        bus.next_song = 1'b1;
        tick();
        bus.next_song = 1'b0;
        wait_note(n);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk_cnt++; if ({bus.note_to_play, bus.duration_to_load} !== exp) $display("FAIL mid_data1: got %h want %h", {bus.note_to_play, bus.duration_to_load}, exp); else pass_cnt++;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_cnt++; if (bus.current_song !== SONG_W'(0)) $display("FAIL mid_song: got %0d want 0", bus.current_song); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(0)) $display("FAIL mid_addr: got %0d want 0", bus.rom_addr); else pass_cnt++;
        chk_cnt++; if ({bus.note_to_play, bus.duration_to_load} !== '0) $display("FAIL mid_note: got %h want 0", {bus.note_to_play, bus.duration_to_load}); else pass_cnt++;
        chk_cnt++; if (bus.dbg.state !== ST_IDLE) $display("FAIL mid_state: got %0d want %0d", bus.dbg.state, ST_IDLE); else pass_cnt++;
        exp_q.push_back(rom[0]);
        wait_note(n);
        chk_cnt++; if (n !== 4) $display("FAIL mid_lat: got %0d want 4", n); else pass_cnt++;
        chk_cnt++; if (bus.rom_addr !== ADDR_W'(0)) $display("FAIL mid_addr0: got %0d want 0", bus.rom_addr); else pass_cnt++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk_cnt++; if ({bus.note_to_play, bus.duration_to_load} !== exp) $display("FAIL mid_data0: got %h want %h", {bus.note_to_play, bus.duration_to_load}, exp); else pass_cnt++;
        chk_cnt++; if (exp_q.size() !== 0) $display("FAIL queue_empty: got %0d entries want 0", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            rom[i] = {NOTE_W'($urandom_range(1, 63)), DUR_W'($urandom_range(1, 63))};
        end
        rom[0]  = {6'd12, 6'd4};
        rom[1]  = {6'd20, 6'd2};
        rom[2]  = {6'd33, 6'd0};
        rom[96] = {6'd7,  6'd3};
        rom[97] = {6'd9,  6'd5};
        bus.play = 1'b0;
        bus.next_song = 1'b0;
        bus.timer_done = 1'b0;
        reset = 1'b1;

        test_reset();
        test_first_note();
        test_advance_and_end();
        test_full_song();
        test_next_song_priority();
        test_reset_mid_note();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
